// File: rtl/nv_ram_rwsthp_param.sv
// Parametrised 1R1W rwsthp register-file RAM: registered read address, registered
// output with bypass, write-first forwarding, post-reset clear engine, sticky range error.
module nv_ram_rwsthp_param #(
  parameter int DEPTH        = 20,
  parameter int WIDTH        = 4,
  parameter int AW           = 5,
  parameter int CLR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic             byp_sel,
  input  logic [WIDTH-1:0] dbyp,
  output logic             init_done,
  output logic             addr_err,
  input  logic             err_clr,
  input  logic [31:0]      pwrbus_ram_pd
);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  state_t           state_r;
  logic [AW-1:0]    clr_addr_r;
  logic             init_done_r;
  logic [AW-1:0]    ra_d_r;
  logic             s1_vld_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_vld_r;
  logic             addr_err_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic             run_s;
  logic             wa_ok_s;
  logic             ra_ok_s;
  logic             err_set_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s;
  logic [WIDTH-1:0] wr_data_s;
  logic [WIDTH-1:0] cap_s;
  logic             unused_pwr_s;

  assign run_s        = (state_r == ST_RUN);
  assign wa_ok_s      = ({1'b0, wa} < DEPTH_W);
  assign ra_ok_s      = ({1'b0, ra} < DEPTH_W);
  assign err_set_s    = run_s & ((we & ~wa_ok_s) | (re & ~ra_ok_s));
  assign unused_pwr_s = ^pwrbus_ram_pd;

  assign dout      = dout_r;
  assign dout_vld  = dout_vld_r;
  assign init_done = init_done_r;
  assign addr_err  = addr_err_r;

  // Control FSM: walks clr_addr across the array once after reset, then enters RUN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_CLEAR;
      clr_addr_r  <= '0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if ((CLR_ON_RESET == 0) || (clr_addr_r == LAST_A)) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end else begin
            clr_addr_r  <= clr_addr_r + AW'(1);
          end
        end
        ST_RUN: begin
          state_r     <= ST_RUN;
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_CLEAR;
          clr_addr_r  <= '0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Array write port mux: the clear engine owns the port until RUN.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = '0;
    wr_data_s = '0;
    if (!run_s) begin
      wr_en_s   = (CLR_ON_RESET != 0);
      wr_addr_s = clr_addr_r;
    end else begin
      wr_en_s   = we & wa_ok_s;
      wr_addr_s = wa;
      wr_data_s = di;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Output capture value: bypass, then invalid read, then write-first forwarding, then array.
  always_comb begin
    cap_s = '0;
    if (byp_sel) begin
      cap_s = dbyp;
    end else if (!s1_vld_r) begin
      cap_s = '0;
    end else if (we && (wa == ra_d_r)) begin
      cap_s = di;
    end else begin
      cap_s = mem_r[ra_d_r];
    end
  end

  // Read pipeline, output register and sticky address error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ra_d_r     <= '0;
      s1_vld_r   <= 1'b0;
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      if (run_s && re) begin
        ra_d_r   <= ra;
        s1_vld_r <= ra_ok_s;
      end
      if (run_s && ore) begin
        dout_r     <= cap_s;
        dout_vld_r <= s1_vld_r | byp_sel;
      end
      if (err_set_s) begin
        addr_err_r <= 1'b1;
      end else if (err_clr) begin
        addr_err_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsthp_param.sv
// Directed self-checking bench for nv_ram_rwsthp_param at default parameters (20x4, clear on reset).
module tb_nv_ram_rwsthp_param;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  ra, wa;
  logic        re, ore, we, byp_sel, err_clr;
  logic [3:0]  di, dbyp, dout;
  logic        dout_vld, init_done, addr_err;
  logic [31:0] pwrbus_ram_pd;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  nv_ram_rwsthp_param dut (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout), .dout_vld(dout_vld),
    .wa(wa), .we(we), .di(di), .byp_sel(byp_sel), .dbyp(dbyp), .init_done(init_done),
    .addr_err(addr_err), .err_clr(err_clr), .pwrbus_ram_pd(pwrbus_ram_pd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    re = 1'b0; ore = 1'b0; we = 1'b0; byp_sel = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] d);
    we = 1'b1; wa = a; di = d;
    step();
    we = 1'b0;
  endtask

  // re in one cycle, ore in the next; dout checked after the second edge
  task automatic rd(input logic [4:0] a, input string tag, input logic [3:0] exp, input logic expv);
    re = 1'b1; ra = a;
    step();
    re = 1'b0; ore = 1'b1;
    step();
    ore = 1'b0;
    chk({tag, "_dout"}, 32'(dout), 32'(exp));
    chk({tag, "_vld"}, 32'(dout_vld), 32'(expv));
  endtask

  task automatic wait_init(input string tag);
    n = 0;
    while (!init_done && n < 40) begin
      step();
      n++;
    end
    chk(tag, n, 32'd20);
  endtask

  initial begin
    rstn = 1'b0; ra = 5'd0; wa = 5'd0; di = 4'h0; dbyp = 4'h0;
    pwrbus_ram_pd = 32'h0;
    idle();
    step();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_vld", 32'(dout_vld), 32'h0);
    chk("rst_init", 32'(init_done), 32'h0);
    chk("rst_err", 32'(addr_err), 32'h0);

    rstn = 1'b1;
    wait_init("init_edges_1");

    // fill with 0xF, confirm, then reset and verify the clear engine zeroed everything
    for (int i = 0; i < 20; i++) wr(5'(i), 4'hF);
    rd(5'd13, "pre_clear", 4'hF, 1'b1);
    rstn = 1'b0;
    step();
    chk("rst2_dout", 32'(dout), 32'h0);
    rstn = 1'b1;
    wait_init("init_edges_2");
    for (int i = 0; i < 20; i++) rd(5'(i), $sformatf("clr%0d", i), 4'h0, 1'b1);

    // basic two-cycle latency
    wr(5'd3, 4'hA);
    rd(5'd3, "basic", 4'hA, 1'b1);

    // write-first forwarding on collision with ra_d
    wr(5'd7, 4'h2);
    re = 1'b1; ra = 5'd7;
    step();
    re = 1'b0; ore = 1'b1; we = 1'b1; wa = 5'd7; di = 4'h9;
    step();
    idle();
    chk("fwd_dout", 32'(dout), 32'h9);
    rd(5'd7, "fwd_after", 4'h9, 1'b1);

    // bypass beats forwarding (ra_d still 7)
    ore = 1'b1; we = 1'b1; wa = 5'd7; di = 4'h3; byp_sel = 1'b1; dbyp = 4'h5;
    step();
    idle();
    chk("byp_dout", 32'(dout), 32'h5);
    chk("byp_vld", 32'(dout_vld), 32'h1);
    rd(5'd7, "byp_wr", 4'h3, 1'b1);

    // out-of-range write then read
    chk("err_pre", 32'(addr_err), 32'h0);
    wr(5'd25, 4'hF);
    chk("err_wa", 32'(addr_err), 32'h1);
    rd(5'd21, "oor", 4'h0, 1'b0);
    chk("err_ra", 32'(addr_err), 32'h1);
    rd(5'd5, "no_alias", 4'h0, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr", 32'(addr_err), 32'h0);
    err_clr = 1'b1; re = 1'b1; ra = 5'd30;
    step();
    idle();
    chk("err_set_wins", 32'(addr_err), 32'h1);

    // bypass with s1_vld=0 (ra_d=30 invalid) still flags valid
    ore = 1'b1; byp_sel = 1'b1; dbyp = 4'h6;
    step();
    chk("byp_inv_dout", 32'(dout), 32'h6);
    chk("byp_inv_vld", 32'(dout_vld), 32'h1);
    byp_sel = 1'b0;
    step();
    idle();
    chk("inv_dout", 32'(dout), 32'h0);
    chk("inv_vld", 32'(dout_vld), 32'h0);

    // re and ore together: capture uses old ra_d
    re = 1'b1; ra = 5'd3;
    step();
    ra = 5'd7; ore = 1'b1;
    step();
    re = 1'b0;
    chk("reore_old", 32'(dout), 32'hA);
    step();
    idle();
    chk("reore_new", 32'(dout), 32'h3);

    // reset mid-clear; writes during clear are ignored
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    repeat (10) step();
    chk("midclr_init", 32'(init_done), 32'h0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    we = 1'b1; wa = 5'd0; di = 4'hF;
    wait_init("init_edges_mid");
    idle();
    rd(5'd0, "clr_ignores_we", 4'h0, 1'b1);
    rd(5'd3, "clr_entry3", 4'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
